// File: rtl/arm_shift_operand_unit.sv
// ARM7TDMI operand-2 shifter front end: two-stage valid/ready pipeline.
// Stage 1 decodes the shift specifier into an effective operation and amount,
// stage 2 performs the shift and holds the result/carry for the consumer.
module arm_shift_operand_unit #(
  parameter int unsigned DATA_W = 32,  // only 32 is supported
  parameter int unsigned AMT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rm_data,
  input  logic [1:0]        shift_type,
  input  logic [AMT_W-1:0]  shift_amt,
  input  logic              imm_shift,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  typedef enum logic [2:0] {
    OpPass,
    OpLsl,
    OpLsr,
    OpAsr,
    OpRor,
    OpRrx
  } op_e;

  // Stage 1 state
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_rm_q;
  logic              s1_cin_q;
  op_e               s1_op_q, s1_op_d;
  logic [AMT_W-1:0]  s1_amt_q, s1_amt_d;

  // Stage 2 state
  logic              s2_valid_q;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;

  logic advance;

  assign advance   = !s2_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;

  // Decode the shift specifier, resolving the immediate #0 special encodings.
  always_comb begin
    logic [4:0] amt5;
    amt5     = shift_amt[4:0];
    s1_op_d  = OpPass;
    s1_amt_d = shift_amt;
    if (imm_shift) begin
      s1_amt_d = {3'b000, amt5};
      if (amt5 == 5'd0) begin
        unique case (shift_type)
          2'b00: s1_op_d = OpPass;
          2'b01: begin
            s1_op_d  = OpLsr;
            s1_amt_d = 8'd32;
          end
          2'b10: begin
            s1_op_d  = OpAsr;
            s1_amt_d = 8'd32;
          end
          default: s1_op_d = OpRrx;
        endcase
      end else begin
        unique case (shift_type)
          2'b00:   s1_op_d = OpLsl;
          2'b01:   s1_op_d = OpLsr;
          2'b10:   s1_op_d = OpAsr;
          default: s1_op_d = OpRor;
        endcase
      end
    end else if (shift_amt != 8'd0) begin
      unique case (shift_type)
        2'b00:   s1_op_d = OpLsl;
        2'b01:   s1_op_d = OpLsr;
        2'b10:   s1_op_d = OpAsr;
        default: s1_op_d = OpRor;
      endcase
    end
  end

  // Barrel shift of the stage 1 operand; extended vectors carry the shifted-out bit.
  always_comb begin
    logic [DATA_W:0]     lsl_ext;
    logic [DATA_W:0]     lsr_ext;
    logic [DATA_W:0]     asr_ext;
    logic [2*DATA_W-1:0] ror_ext;
    logic                lt32;
    logic                eq32;
    lsl_ext  = {1'b0, s1_rm_q} << s1_amt_q[4:0];
    lsr_ext  = {s1_rm_q, 1'b0} >> s1_amt_q[4:0];
    asr_ext  = $signed({s1_rm_q, 1'b0}) >>> s1_amt_q[4:0];
    ror_ext  = {s1_rm_q, s1_rm_q} >> s1_amt_q[4:0];
    lt32     = s1_amt_q < 8'd32;
    eq32     = s1_amt_q == 8'd32;
    result_d = s1_rm_q;
    carry_d  = s1_cin_q;
    unique case (s1_op_q)
      OpLsl: begin
        if (lt32) begin
          result_d = lsl_ext[DATA_W-1:0];
          carry_d  = lsl_ext[DATA_W];
        end else begin
          result_d = '0;
          carry_d  = eq32 ? s1_rm_q[0] : 1'b0;
        end
      end
      OpLsr: begin
        if (lt32) begin
          result_d = lsr_ext[DATA_W:1];
          carry_d  = lsr_ext[0];
        end else begin
          result_d = '0;
          carry_d  = eq32 ? s1_rm_q[DATA_W-1] : 1'b0;
        end
      end
      OpAsr: begin
        if (lt32) begin
          result_d = asr_ext[DATA_W:1];
          carry_d  = asr_ext[0];
        end else begin
          result_d = {DATA_W{s1_rm_q[DATA_W-1]}};
          carry_d  = s1_rm_q[DATA_W-1];
        end
      end
      OpRor: begin
        // A multiple of 32 leaves the operand intact but still updates C.
        if (s1_amt_q[4:0] == 5'd0) begin
          result_d = s1_rm_q;
          carry_d  = s1_rm_q[DATA_W-1];
        end else begin
          result_d = ror_ext[DATA_W-1:0];
          carry_d  = ror_ext[DATA_W-1];
        end
      end
      OpRrx: begin
        result_d = {s1_cin_q, s1_rm_q[DATA_W-1:1]};
        carry_d  = s1_rm_q[0];
      end
      default: begin
        result_d = s1_rm_q;
        carry_d  = s1_cin_q;
      end
    endcase
  end

  // Pipeline registers: everything holds while the output stage is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_rm_q    <= '0;
      s1_cin_q   <= 1'b0;
      s1_op_q    <= OpPass;
      s1_amt_q   <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_rm_q  <= rm_data;
        s1_cin_q <= carry_in;
        s1_op_q  <= s1_op_d;
        s1_amt_q <= s1_amt_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        carry_q  <= carry_d;
      end
    end
  end

endmodule

// File: doc/arm_shift_operand_unit.md
Name: arm_shift_operand_unit

Overview:
- Pipelined ARM7TDMI operand-2 shifter front end: accepts Rm plus an ARM shift specifier and returns the shifted operand and shifter carry-out.
- Sits between register-read/decode and the ALU; it is the consumer-side counterpart of the combinational barrel shifter.
- Covers full ARM semantics for LSL/LSR/ASR/ROR/RRX, with both immediate- and register-specified amounts.
- Uses a 2-stage valid/ready pipeline with a global stall.

Parameters:
- DATA_W, 32, operand width. Only 32 is supported; it exists for documentation.
- AMT_W, 8, width of a register-specified shift amount (Rs[7:0]).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- rm_data  in  32  operand to shift
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- shift_amt  in  8  shift amount; only [4:0] is used when imm_shift=1
- imm_shift  in  1  1 = immediate-encoded amount (special #0 meanings); 0 = register-specified
- carry_in  in  1  current CPSR C flag, sampled with the request
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  shifted operand
- carry_out  out  1  shifter carry-out

Behaviour:
- Reset (rst=1 at an edge):
  - s1_valid=0, s2_valid=0; out_valid=0, result=0, carry_out=0.
  - in_ready=1 in the first cycle after reset.
  - Any in-flight data is discarded with no output.
- Handshakes:
  - advance = !s2_valid | out_ready; in_ready = advance (combinational).
  - Input transfer happens when in_valid & in_ready. Output transfer happens when out_valid & out_ready.
  - On advance, s2 takes s1 and s1 takes the input; s1_valid := in_valid.
  - When advance=0, all stage registers hold and out_valid/result/carry_out stay stable.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput is 1 per cycle.
- Stage 1 (decode/normalise) registers Rm, carry_in, and the effective operation:
  - Immediate, amt[4:0]=0:
    - LSL -> pass, C=carry_in.
    - LSR -> treated as LSR#32.
    - ASR -> treated as ASR#32.
    - ROR -> RRX.
  - Register, amt=0: pass, C=carry_in, for all types.
  - All other cases: type and amount pass through unchanged.
- Stage 2 (shift) computes result/carry. Here n = effective amount and r = Rm.
  - LSL 1..31: r<<n, C=r[32-n]. LSL 32: 0, C=r[0]. LSL >32: 0, C=0.
  - LSR 1..31: r>>n, C=r[n-1]. LSR 32: 0, C=r[31]. LSR >32: 0, C=0.
  - ASR 1..31: arithmetic shift, C=r[n-1]. ASR >=32: all bits = r[31], C=r[31].
  - ROR, n[4:0]!=0: rotate right by n[4:0], C=r[n[4:0]-1].
  - ROR, n!=0 and n[4:0]=0 (e.g. 32, 64, 224): result=r, C=r[31].
  - RRX: {carry_in, r[31:1]}, C=r[0].
- Width rules:
  - Amounts are unsigned, 0..255. No modulo wrap except ROR, which uses n[4:0].
  - The immediate path ignores shift_amt[7:5].
- Boundary cases:
  - Simultaneous input accept and output drain in the same cycle is legal and loses no data.
  - out_ready=0 with both stages full forces in_ready=0. Upstream must hold its inputs.
  - rst asserted mid-stream wins over everything; no partial result appears after reset.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, result=0, carry_out=0, in_ready=1.
- Immediate specials:
  - rm=0x80000001, imm LSR #0 -> result 0x00000000, C=1.
  - imm ASR #0 -> 0xFFFFFFFF, C=1.
  - imm ROR #0, carry_in=1 -> 0xC0000000, C=1.
- Register amounts:
  - rm=0x00000001, reg LSL 32 -> 0, C=1.
  - reg LSL 33 -> 0, C=0.
  - reg ROR 32 with rm=0x80000000 -> 0x80000000, C=1.
  - reg LSR 0, carry_in=0 -> rm unchanged, C=0.
- Normal shifts:
  - rm=0x0000000F, imm LSL 4 -> 0x000000F0, C=0.
  - rm=0x80000000, imm ASR 4 -> 0xF8000000, C=0.
  - rm=0x00000001, reg ROR 1 -> 0x80000000, C=1.
- Backpressure: stream 4 back-to-back requests with out_ready=0 for 3 cycles -> in_ready drops once 2 entries are held; all 4 results emerge in order with none lost or duplicated.
- Reset mid-operation: rst pulsed while 2 requests are in flight -> out_valid=0 the next cycle and neither result is ever presented.
